// File: rtl/mlp_seq_accel_if.sv
// mlp_seq_accel_if -- host/memory bus of the sequential MLP classifier.
//   start            host request for one inference (single cycle)
//   x_addr / x_data  input-pixel memory address and read data (1-cycle latency)
//   w_addr / w_data  weight/bias memory address and read data (1-cycle latency)
//   rd_en            read strobe shared by both memories
//   busy / done      run in progress / one-cycle result-valid pulse
//   predicted_digit  winning class index, held until the next done
//   max_score        winning class score, held until the next done
// slave modport: accelerator side. master modport: host + memory side.
interface mlp_seq_accel_if #(
  parameter int DATA_W = 32,
  parameter int IN_DIM = 784,
  parameter int WA_W   = 20
);
  localparam int XA_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;

  logic              start;
  logic [XA_W-1:0]   x_addr;
  logic [DATA_W-1:0] x_data;
  logic [WA_W-1:0]   w_addr;
  logic [DATA_W-1:0] w_data;
  logic              rd_en;
  logic              busy;
  logic              done;
  logic [3:0]        predicted_digit;
  logic [DATA_W-1:0] max_score;

  modport slave (
    input  start, x_data, w_data,
    output x_addr, w_addr, rd_en, busy, done, predicted_digit, max_score
  );

  modport master (
    output start, x_data, w_data,
    input  x_addr, w_addr, rd_en, busy, done, predicted_digit, max_score
  );
endinterface

// File: rtl/mlp_seq_accel.sv
// mlp_seq_accel -- time-multiplexed two-layer MLP classifier.
// One signed MAC walks every neuron of the hidden layer (ReLU, stored in an
// internal buffer) and then every output neuron, keeping a running argmax.
// Each neuron with N inputs takes N+2 cycles: N operand reads, a bias read
// (last product accumulated), then the bias-add/round/saturate/write cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    mlp_seq_accel_if.slave (start, memory address/data, rd_en,
//          busy, done, predicted_digit, max_score)
module mlp_seq_accel #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 24,
  parameter int IN_DIM  = 784,
  parameter int HID_DIM = 128,
  parameter int OUT_DIM = 10,
  parameter int ACC_W   = 2*DATA_W+8,
  parameter int WA_W    = 20
) (
  input  logic            clk,
  input  logic            reset,
  mlp_seq_accel_if.slave  bus
);
  localparam int XA_W    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int HA_W    = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int N_MAX   = (IN_DIM > HID_DIM) ? IN_DIM : HID_DIM;
  localparam int CNT_W   = $clog2(N_MAX + 2);
  localparam int NEU_MAX = (HID_DIM > OUT_DIM) ? HID_DIM : OUT_DIM;
  localparam int NEU_W   = (NEU_MAX > 1) ? $clog2(NEU_MAX) : 1;

  localparam logic [WA_W-1:0] B1_BASE = WA_W'(HID_DIM*IN_DIM);
  localparam logic [WA_W-1:0] W2_BASE = WA_W'(HID_DIM*IN_DIM + HID_DIM);
  localparam logic [WA_W-1:0] B2_BASE = WA_W'(HID_DIM*IN_DIM + HID_DIM + OUT_DIM*HID_DIM);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_L1, S_L2, S_FIN} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NEU_W-1:0]          neu_q, neu_d;
  logic [WA_W-1:0]           row_q, row_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  op_q, op_d;
  logic signed [DATA_W-1:0]  best_q, best_d;
  logic [3:0]                best_idx_q, best_idx_d;
  logic [3:0]                pred_q, pred_d;
  logic [DATA_W-1:0]         score_q, score_d;

  logic signed [DATA_W-1:0]  hid_mem [HID_DIM];
  logic                      hid_we;
  logic signed [DATA_W-1:0]  hid_wdata;

  logic                      in_slot, issue, bias_rd, wr_slot, last_neu;
  logic [CNT_W-1:0]          n_len;
  logic signed [DATA_W-1:0]  operand;
  logic signed [2*DATA_W-1:0] op_ext, w_ext, prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_ext, bias_sh, sum, res_sh;
  logic signed [DATA_W-1:0]  res_w, win_val;
  logic [3:0]                win_idx;
  logic                      take;

  // Slot bookkeeping and datapath
  always_comb begin
    in_slot  = (state_q == S_L1) || (state_q == S_L2);
    n_len    = (state_q == S_L1) ? CNT_W'(IN_DIM) : CNT_W'(HID_DIM);
    last_neu = (state_q == S_L1) ? (neu_q == NEU_W'(HID_DIM-1)) : (neu_q == NEU_W'(OUT_DIM-1));
    issue    = in_slot && (cnt_q < n_len);
    bias_rd  = in_slot && (cnt_q == n_len);
    wr_slot  = in_slot && (cnt_q == n_len + CNT_W'(1));

    // In L2 the hidden operand was fetched one cycle early so it lines up with w_data.
    operand  = (state_q == S_L1) ? $signed(bus.x_data) : op_q;
    op_ext   = {{DATA_W{operand[DATA_W-1]}}, operand};
    w_ext    = {{DATA_W{bus.w_data[DATA_W-1]}}, bus.w_data};
    prod     = op_ext * w_ext;
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    bias_ext = {{(ACC_W-DATA_W){bus.w_data[DATA_W-1]}}, bus.w_data};
    bias_sh  = bias_ext <<< FRAC_W;
    sum      = acc_q + bias_sh;
    res_sh   = sum >>> FRAC_W;
    if (res_sh > SAT_MAX)      res_w = SAT_MAX[DATA_W-1:0];
    else if (res_sh < SAT_MIN) res_w = SAT_MIN[DATA_W-1:0];
    else                       res_w = res_sh[DATA_W-1:0];

    take    = (neu_q == '0) || (res_w > best_q);
    win_val = take ? res_w : best_q;
    win_idx = take ? 4'(neu_q) : best_idx_q;
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    neu_d      = neu_q;
    row_d      = row_q;
    acc_d      = acc_q;
    op_d       = op_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    pred_d     = pred_q;
    score_d    = score_q;
    hid_we     = 1'b0;
    hid_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_L1;
          cnt_d   = '0;
          neu_d   = '0;
          row_d   = '0;
        end
      end
      S_L1, S_L2: begin
        if (cnt_q == '0)         acc_d = '0;
        else if (cnt_q <= n_len) acc_d = acc_q + prod_ext;

        if ((state_q == S_L2) && issue) op_d = hid_mem[cnt_q[HA_W-1:0]];

        cnt_d = cnt_q + CNT_W'(1);
        if (wr_slot) begin
          cnt_d = '0;
          neu_d = neu_q + NEU_W'(1);
          if (state_q == S_L1) begin
            hid_we    = 1'b1;
            hid_wdata = res_w[DATA_W-1] ? '0 : res_w;
            row_d     = row_q + WA_W'(IN_DIM);
            if (last_neu) begin
              state_d = S_L2;
              neu_d   = '0;
              row_d   = W2_BASE;
            end
          end else begin
            best_d     = win_val;
            best_idx_d = win_idx;
            row_d      = row_q + WA_W'(HID_DIM);
            if (last_neu) begin
              // Publish the final winner directly so it is valid alongside done.
              state_d = S_FIN;
              pred_d  = win_idx;
              score_d = win_val;
            end
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      neu_q      <= '0;
      row_q      <= '0;
      acc_q      <= '0;
      op_q       <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      pred_q     <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      neu_q      <= neu_d;
      row_q      <= row_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      pred_q     <= pred_d;
      score_q    <= score_d;
    end
  end

  // Hidden activations need no reset; every entry is written before use.
  always_ff @(posedge clk) begin
    if (hid_we) hid_mem[neu_q[HA_W-1:0]] <= hid_wdata;
  end

  // Memory request and status outputs
  always_comb begin
    bus.x_addr = '0;
    bus.w_addr = '0;
    if (issue) begin
      if (state_q == S_L1) bus.x_addr = cnt_q[XA_W-1:0];
      bus.w_addr = row_q + WA_W'(cnt_q);
    end else if (bias_rd) begin
      bus.w_addr = ((state_q == S_L1) ? B1_BASE : B2_BASE) + WA_W'(neu_q);
    end
    bus.rd_en           = issue || bias_rd;
    bus.busy            = in_slot;
    bus.done            = (state_q == S_FIN);
    bus.predicted_digit = pred_q;
    bus.max_score       = score_q;
  end
endmodule

// File: tb/tb_mlp_seq_accel.sv
// tb_mlp_seq_accel -- self-checking bench for mlp_seq_accel with a small
// configuration (16-bit Q8.8, 4 inputs, 3 hidden, 2 classes).
module tb_mlp_seq_accel;
  localparam int DW   = 16;
  localparam int FW   = 8;
  localparam int ID   = 4;
  localparam int HD   = 3;
  localparam int OD   = 2;
  localparam int WAW  = 5;
  localparam int LAT  = HD*(ID+2) + OD*(HD+2) + 1;
  localparam int B1A  = HD*ID;
  localparam int W2A  = HD*ID + HD;
  localparam int B2A  = W2A + OD*HD;
  localparam longint SMAX = (longint'(1) <<< (DW-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (DW-1));

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mlp_seq_accel_if #(.DATA_W(DW), .IN_DIM(ID), .WA_W(WAW)) bus ();

  mlp_seq_accel #(
    .DATA_W(DW), .FRAC_W(FW), .IN_DIM(ID), .HID_DIM(HD),
    .OUT_DIM(OD), .ACC_W(2*DW+8), .WA_W(WAW)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  logic [DW-1:0] xm [ID];
  logic [DW-1:0] wm [1<<WAW];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.x_data <= xm[bus.x_addr];
      bus.w_data <= wm[bus.w_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  task automatic model_infer(output int p, output int s);
    longint hid [HD];
    longint acc, r, bv;
    int bi;
    bv = 0;
    bi = 0;
    for (int h = 0; h < HD; h++) begin
      acc = 0;
      for (int i = 0; i < ID; i++) acc += sx(xm[i]) * sx(wm[h*ID+i]);
      r = sat((acc + sx(wm[B1A+h]) * (longint'(1) <<< FW)) >>> FW);
      hid[h] = (r < 0) ? 0 : r;
    end
    for (int o = 0; o < OD; o++) begin
      acc = 0;
      for (int j = 0; j < HD; j++) acc += hid[j] * sx(wm[W2A+o*HD+j]);
      r = sat((acc + sx(wm[B2A+o]) * (longint'(1) <<< FW)) >>> FW);
      if (o == 0 || r > bv) begin
        bv = r;
        bi = o;
      end
    end
    p = bi;
    s = int'(bv);
  endtask

  // phase: -1 idle, k = k-th cycle after the accepting edge (LAT = done cycle)
  int phase = -1;
  logic [3:0]    exp_pred  = '0;
  logic [DW-1:0] exp_score = '0;
  int pend_p, pend_s;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      phase     = -1;
      exp_pred  = '0;
      exp_score = '0;
    end else if (phase == -1) begin
      if (bus.start) begin
        model_infer(pend_p, pend_s);
        phase = 1;
      end
    end else if (phase == LAT) begin
      phase = -1;
    end else begin
      phase++;
      if (phase == LAT) begin
        exp_pred  = pend_p[3:0];
        exp_score = pend_s[DW-1:0];
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      automatic bit exp_rd = 1'b0;
      automatic bit exp_xa = 1'b0;
      automatic int ew = 0;
      automatic int ex = 0;
      if (phase >= 1 && phase <= HD*(ID+2)) begin
        automatic int p = phase - 1;
        automatic int sl = p / (ID+2);
        automatic int c = p % (ID+2);
        exp_rd = (c <= ID);
        if (c < ID) begin
          ew = sl*ID + c;
          ex = c;
          exp_xa = 1'b1;
        end else begin
          ew = B1A + sl;
        end
      end else if (phase > HD*(ID+2) && phase < LAT) begin
        automatic int q = phase - 1 - HD*(ID+2);
        automatic int sl = q / (HD+2);
        automatic int c = q % (HD+2);
        exp_rd = (c <= HD);
        ew = (c < HD) ? (W2A + sl*HD + c) : (B2A + sl);
      end
      check("busy",  bus.busy, (phase >= 1 && phase < LAT));
      check("done",  bus.done, (phase == LAT));
      check("pred",  bus.predicted_digit, exp_pred);
      check("score", bus.max_score, exp_score);
      check("rd_en", bus.rd_en, exp_rd);
      if (exp_rd) check("w_addr", bus.w_addr, ew);
      if (exp_xa) check("x_addr", bus.x_addr, ex);
    end
  end

  // ---------------- stimulus ----------------
  task automatic fill(input logic [DW-1:0] xv, w1v, b1v, w2a, w2b, b2a, b2b);
    for (int i = 0; i < ID; i++) xm[i] = xv;
    for (int k = 0; k < (1<<WAW); k++) wm[k] = '0;
    for (int k = 0; k < HD*ID; k++) wm[k] = w1v;
    for (int h = 0; h < HD; h++) wm[B1A+h] = b1v;
    for (int j = 0; j < HD; j++) begin
      wm[W2A+j]    = w2a;
      wm[W2A+HD+j] = w2b;
    end
    wm[B2A]   = b2a;
    wm[B2A+1] = b2b;
  endtask

  // Called at a negedge with the DUT idle; start is raised for one cycle and
  // re-raised in phases s1/s2, where it must be ignored.
  task automatic do_run(input int s1, input int s2);
    int k;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (phase != -1 && k < LAT + 10) begin
      bus.start = (phase == s1 || phase == s2);
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    check("run_complete", (phase == -1), 1'b1);
  endtask

  task automatic expect_result(input string name, input logic [3:0] p, input logic [DW-1:0] s);
    check({name, "_pred"},  bus.predicted_digit, p);
    check({name, "_score"}, bus.max_score, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    fill('0, '0, '0, '0, '0, '0, '0);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  bus.busy, 1'b0);
    check("rst_done",  bus.done, 1'b0);
    check("rst_rd_en", bus.rd_en, 1'b0);
    check("rst_xaddr", bus.x_addr, '0);
    check("rst_waddr", bus.w_addr, '0);
    expect_result("rst", 4'd0, '0);
    chk_en = 1'b1;

    // Basic run
    fill(16'h0100, 16'h0080, 16'h0000, 16'h0100, 16'hFF00, 16'h0000, 16'h0000);
    do_run(0, 0);
    expect_result("basic", 4'd0, 16'h0600);

    // ReLU clamps the hidden layer; biases decide
    fill(16'h0100, 16'hFF80, 16'h0000, 16'h0100, 16'hFF00, 16'h0040, 16'h00C0);
    do_run(0, 0);
    expect_result("relu", 4'd1, 16'h00C0);

    // Tie keeps the lower index
    fill(16'h0100, 16'h0080, 16'h0000, 16'h0100, 16'h0100, 16'h0010, 16'h0010);
    do_run(0, 0);
    expect_result("tie", 4'd0, 16'h0610);

    // Positive saturation in both layers
    fill(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
    do_run(0, 0);
    expect_result("sat", 4'd0, 16'h7FFF);

    // -0.5 LSB hidden result floors to -1 and ReLU turns it into 0
    fill(16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'hFF00, 16'h0000, 16'h0000);
    xm[0] = 16'h0001;
    for (int h = 0; h < HD; h++) wm[h*ID] = 16'hFF80;
    do_run(0, 0);
    expect_result("trunc", 4'd0, 16'h0000);

    // Reset mid-run after a nonzero result was published
    fill(16'h0100, 16'hFF80, 16'h0000, 16'h0100, 16'hFF00, 16'h0040, 16'h00C0);
    do_run(0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 20 && phase != 10; k++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    expect_result("abort", 4'd0, '0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    do_run(0, 0);
    expect_result("rerun", 4'd1, 16'h00C0);

    // Starts while busy are ignored; a start right after done is accepted
    fill(16'h0100, 16'h0080, 16'h0000, 16'h0100, 16'hFF00, 16'h0000, 16'h0000);
    do_run(5, 20);
    expect_result("ignore", 4'd0, 16'h0600);
    fill(16'h0100, 16'hFF80, 16'h0000, 16'h0100, 16'hFF00, 16'h0040, 16'h00C0);
    do_run(0, 0);
    expect_result("b2b", 4'd1, 16'h00C0);

    // Randomized runs against the model
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < ID; i++)
        xm[i] = (r % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 1023)) - DW'(512);
      for (int k = 0; k < B2A + OD; k++)
        wm[k] = (r % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 1023)) - DW'(512);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run($urandom_range(1, LAT), $urandom_range(1, LAT));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
